// File: rtl/inv_clark_pipe_if.sv
// Sample/result bus of the inverse Clarke pipeline.
// Handshake: a sample is taken on a rising edge where iValid and oReady are both high;
// the source holds the sample until then, and oValid is a one-cycle pulse with no back-pressure.
interface inv_clark_pipe_if #(
    parameter int DW  = 16,
    parameter int CHW = 2
);
    logic                  iValid;
    logic                  oReady;
    logic                  iMode;
    logic [CHW-1:0]        iCh;
    logic signed [DW-1:0]  iValpha;
    logic signed [DW-1:0]  iVbeta;
    logic signed [DW-1:0]  oV1;
    logic signed [DW-1:0]  oV2;
    logic signed [DW-1:0]  oV3;
    logic [CHW-1:0]        oCh;
    logic                  oValid;
    logic                  oSat;

    modport master (
        output iValid, iMode, iCh, iValpha, iVbeta,
        input  oReady, oV1, oV2, oV3, oCh, oValid, oSat
    );

    modport slave (
        input  iValid, iMode, iCh, iValpha, iVbeta,
        output oReady, oV1, oV2, oV3, oCh, oValid, oSat
    );
endinterface

// File: rtl/inv_clark_pipe.sv
// Inverse Clarke transform: alpha/beta to three phase voltages, one shared
// multiplier sequenced IDLE -> MUL -> SUM, with rounding and optional saturation.
module inv_clark_pipe #(
    parameter int DW        = 16,
    parameter int CW        = 10,
    parameter int K_SQRT3_2 = 887,
    parameter int CHW       = 2,
    parameter int SAT       = 1
) (
    input  logic              iClk,
    input  logic              iRst,
    inv_clark_pipe_if.slave   bus,
    output logic [1:0]        oDbgState
);
    localparam int PW = DW + CW + 1;
    localparam int SW = DW + 2;
    localparam logic signed [SW-1:0] MAXV = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {3'b111, {(DW-1){1'b0}}};
    localparam logic signed [PW-1:0] RND  = PW'(1) <<< (CW - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, SUM = 2'd2} state_t;

    state_t               state_q;
    logic signed [DW-1:0] alpha_q, beta_q;
    logic                 mode_q;
    logic [CHW-1:0]       ch_q;
    logic signed [DW:0]   kx_q;
    logic signed [DW-1:0] h_q;
    logic signed [DW-1:0] v1_q, v2_q, v3_q;
    logic [CHW-1:0]       och_q;
    logic                 valid_q, sat_q, ready_q;

    logic signed [DW-1:0] x_d, other_d, h_d;
    logic signed [PW-1:0] p_d;
    logic signed [DW:0]   kx_d;
    logic signed [SW-1:0] s1_d, s2_d, s3_d;
    logic signed [DW-1:0] v1_d, v2_d, v3_d;
    logic                 c1_d, c2_d, c3_d, sat_d;

    // Returns {clamped, value}; with SAT = 0 the low DW bits wrap.
    function automatic logic [DW:0] fit(input logic signed [SW-1:0] s);
        if (SAT != 0 && s > MAXV) return {1'b1, MAXV[DW-1:0]};
        if (SAT != 0 && s < MINV) return {1'b1, MINV[DW-1:0]};
        return {1'b0, s[DW-1:0]};
    endfunction

    always_comb begin
        // Mode 0 scales beta and halves alpha; mode 1 swaps the roles.
        x_d     = mode_q ? alpha_q : beta_q;
        other_d = mode_q ? beta_q  : alpha_q;
        p_d     = {{(CW+1){x_d[DW-1]}}, x_d} * PW'(K_SQRT3_2);
        kx_d    = (DW+1)'((p_d + RND) >>> CW);
        h_d     = other_d >>> 1;

        s1_d = SW'(mode_q ? beta_q : alpha_q);
        s2_d = SW'(kx_q) - SW'(h_q);
        s3_d = -SW'(kx_q) - SW'(h_q);
        {c1_d, v1_d} = fit(s1_d);
        {c2_d, v2_d} = fit(s2_d);
        {c3_d, v3_d} = fit(s3_d);
        sat_d = c1_d | c2_d | c3_d;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            alpha_q <= '0;
            beta_q  <= '0;
            mode_q  <= 1'b0;
            ch_q    <= '0;
            kx_q    <= '0;
            h_q     <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            v3_q    <= '0;
            och_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (bus.iValid) begin
                        alpha_q <= bus.iValpha;
                        beta_q  <= bus.iVbeta;
                        mode_q  <= bus.iMode;
                        ch_q    <= bus.iCh;
                        ready_q <= 1'b0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    kx_q    <= kx_d;
                    h_q     <= h_d;
                    state_q <= SUM;
                end
                SUM: begin
                    v1_q    <= v1_d;
                    v2_q    <= v2_d;
                    v3_q    <= v3_d;
                    och_q   <= ch_q;
                    sat_q   <= sat_d;
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oReady = ready_q;
    assign bus.oV1    = v1_q;
    assign bus.oV2    = v2_q;
    assign bus.oV3    = v3_q;
    assign bus.oCh    = och_q;
    assign bus.oValid = valid_q;
    assign bus.oSat   = sat_q;
    assign oDbgState  = state_q;
endmodule

// File: tb/tb_inv_clark_pipe.sv
// Directed bench for inv_clark_pipe: a saturating and a wrapping instance run in lockstep.
module tb_inv_clark_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_a, dbg_b;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         valid_cyc = 0;
    int         prev_cyc = 0;
    int         seen;

    inv_clark_pipe_if #(.DW(16), .CHW(2)) bus_a ();
    inv_clark_pipe_if #(.DW(16), .CHW(2)) bus_b ();

    assign bus_b.iValid  = bus_a.iValid;
    assign bus_b.iMode   = bus_a.iMode;
    assign bus_b.iCh     = bus_a.iCh;
    assign bus_b.iValpha = bus_a.iValpha;
    assign bus_b.iVbeta  = bus_a.iVbeta;

    inv_clark_pipe #(.DW(16), .CW(10), .K_SQRT3_2(887), .CHW(2), .SAT(1)) dut_sat (
        .iClk(clk), .iRst(rst), .bus(bus_a), .oDbgState(dbg_a)
    );
    inv_clark_pipe #(.DW(16), .CW(10), .K_SQRT3_2(887), .CHW(2), .SAT(0)) dut_wrap (
        .iClk(clk), .iRst(rst), .bus(bus_b), .oDbgState(dbg_b)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Drives one sample, waits for its result and checks both instances.
    task automatic run_vec(input logic mode, input logic [1:0] ch, input int a, input int b,
                           input int e1, input int e2, input int e3, input int esat,
                           input int w2, input int wsat, input bit keep);
        int n;
        int low;
        bus_a.iMode   = mode;
        bus_a.iCh     = ch;
        bus_a.iValpha = 16'(a);
        bus_a.iVbeta  = 16'(b);
        bus_a.iValid  = 1'b1;
        n = 0;
        while (!bus_a.oReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", int'(bus_a.oReady), 1);
        @(posedge clk);
        #1;
        if (!keep) bus_a.iValid = 1'b0;
        bus_a.iValpha = 16'sh1234;
        bus_a.iVbeta  = -16'sd77;
        bus_a.iMode   = ~mode;
        bus_a.iCh     = ~ch;
        n   = 0;
        low = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus_a.oReady && !bus_a.oValid) low++;
        end while (!bus_a.oValid && n < 10);
        valid_cyc = cyc;
        check("latency", n, 3);
        check("ready_low_cycles", low, 2);
        check("ready_with_valid", int'(bus_a.oReady), 1);
        check("v1", int'(bus_a.oV1), e1);
        check("v2", int'(bus_a.oV2), e2);
        check("v3", int'(bus_a.oV3), e3);
        check("och", int'(bus_a.oCh), int'(ch));
        check("osat", int'(bus_a.oSat), esat);
        check("wrap_valid", int'(bus_b.oValid), 1);
        check("wrap_v1", int'(bus_b.oV1), e1);
        check("wrap_v2", int'(bus_b.oV2), w2);
        check("wrap_v3", int'(bus_b.oV3), e3);
        check("wrap_osat", int'(bus_b.oSat), wsat);
    endtask

    initial begin
        rst           = 1'b1;
        bus_a.iValid  = 1'b1;
        bus_a.iMode   = 1'b1;
        bus_a.iCh     = 2'd2;
        bus_a.iValpha = 16'sd1000;
        bus_a.iVbeta  = 16'sd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", int'(bus_a.oReady), 0);
        check("rst_valid", int'(bus_a.oValid), 0);
        check("rst_v1", int'(bus_a.oV1), 0);
        check("rst_v2", int'(bus_a.oV2), 0);
        check("rst_v3", int'(bus_a.oV3), 0);
        check("rst_och", int'(bus_a.oCh), 0);
        check("rst_osat", int'(bus_a.oSat), 0);
        check("rst_state", int'(dbg_a), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_release", int'(bus_a.oReady), 1);

        // driver: directed vectors
        run_vec(1'b1, 2'd2, 1000, 0, 0, 866, -866, 0, 866, 0, 1'b0);
        @(negedge clk);
        check("valid_one_cycle", int'(bus_a.oValid), 0);
        check("hold_v2", int'(bus_a.oV2), 866);
        check("hold_och", int'(bus_a.oCh), 2);
        run_vec(1'b0, 2'd1, 1000, 0, 1000, -500, -500, 0, -500, 0, 1'b0);
        run_vec(1'b0, 2'd3, 0, 1000, 0, 866, -866, 0, 866, 0, 1'b0);
        run_vec(1'b1, 2'd0, -1000, 0, 0, -866, 866, 0, -866, 0, 1'b0);
        run_vec(1'b1, 2'd1, 32767, -32768, -32768, 32767, -11999, 1, -20769, 0, 1'b0);
        run_vec(1'b0, 2'd0, -3, 0, -3, 2, 2, 0, 2, 0, 1'b0);

        // back-to-back with iValid held high
        for (int k = 0; k < 4; k++) begin
            prev_cyc = valid_cyc;
            run_vec(1'b0, 2'(k), 100 * (k + 1), 0, 100 * (k + 1), -50 * (k + 1), -50 * (k + 1), 0,
                    -50 * (k + 1), 0, 1'b1);
            if (k > 0) check("b2b_spacing", valid_cyc - prev_cyc, 3);
        end
        bus_a.iValid = 1'b0;

        // reset during MUL
        bus_a.iMode   = 1'b1;
        bus_a.iCh     = 2'd3;
        bus_a.iValpha = 16'sd1000;
        bus_a.iVbeta  = 16'sd0;
        bus_a.iValid  = 1'b1;
        @(posedge clk);
        #1;
        bus_a.iValid = 1'b0;
        @(negedge clk);
        check("mid_state_mul", int'(dbg_a), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_v1", int'(bus_a.oV1), 0);
        check("mid_rst_v2", int'(bus_a.oV2), 0);
        check("mid_rst_och", int'(bus_a.oCh), 0);
        check("mid_rst_ready", int'(bus_a.oReady), 0);
        check("mid_rst_state", int'(dbg_a), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_ready_low", int'(bus_a.oReady), 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_a.oValid || bus_b.oValid) seen++;
        end
        check("mid_no_valid", seen, 0);
        check("mid_ready_high", int'(bus_a.oReady), 1);
        check("mid_v3_zero", int'(bus_a.oV3), 0);

        // report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
